// File: rtl/instr_mem_loader.sv
// rtl/instr_mem_loader.sv - byte-stream to 32-bit word loader for the instruction memory
//
// Purpose: packs an incoming program-image byte stream into words, writes them
// into the instruction memory from address 0 upward, and holds the CPU until
// the whole image has been written.
//
// Ports:
//   clk, reset            clock and synchronous active-high reset
//   start                 one-cycle pulse, begins a load (ignored while loading)
//   byte_in/byte_valid/byte_last/byte_ready   image byte stream handshake
//   mem_we/mem_addr/mem_wdata                 instruction memory write port
//   words_loaded          words written in the current or last load
//   busy/done/overflow_err/cpu_hold           status
module instr_mem_loader #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_WORDS  = 2**ADDR_WIDTH,
  parameter bit BIG_ENDIAN = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [7:0]            byte_in,
  input  logic                  byte_valid,
  input  logic                  byte_last,
  output logic                  byte_ready,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic [ADDR_WIDTH:0]   words_loaded,
  output logic                  busy,
  output logic                  done,
  output logic                  overflow_err,
  output logic                  cpu_hold
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DONE, S_ERROR} state_e;

  localparam logic [ADDR_WIDTH:0] MAX_CNT = (ADDR_WIDTH+1)'(MAX_WORDS);

  state_e                state_q;
  logic [1:0]            byte_cnt_q;
  logic [DATA_WIDTH-1:0] asm_q;
  logic                  last_q;
  logic [ADDR_WIDTH:0]   words_loaded_q;
  logic                  mem_we_q;
  logic [ADDR_WIDTH-1:0] mem_addr_q;
  logic [DATA_WIDTH-1:0] mem_wdata_q;
  logic                  byte_ready_q;
  logic                  busy_q;
  logic                  done_q;
  logic                  overflow_q;
  logic                  cpu_hold_q;

  logic [1:0]            lane_d;
  logic [DATA_WIDTH-1:0] word_d;
  logic                  accept;

  assign accept = byte_valid & byte_ready_q;

  // Word as it stands once the incoming byte is dropped into its lane.
  // Lanes not yet filled are still zero, which gives the padding for a short
  // final word for free.
  always_comb begin
    lane_d = BIG_ENDIAN ? (2'd3 - byte_cnt_q) : byte_cnt_q;
    word_d = asm_q;
    for (int i = 0; i < 4; i++) begin
      if (lane_d == 2'(i)) begin
        word_d[8*i +: 8] = byte_in;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= S_IDLE;
      byte_cnt_q     <= 2'd0;
      asm_q          <= '0;
      last_q         <= 1'b0;
      words_loaded_q <= '0;
      mem_we_q       <= 1'b0;
      mem_addr_q     <= '0;
      mem_wdata_q    <= '0;
      byte_ready_q   <= 1'b0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      overflow_q     <= 1'b0;
      cpu_hold_q     <= 1'b1;
    end else begin
      mem_we_q <= 1'b0;
      case (state_q)
        S_IDLE, S_DONE, S_ERROR: begin
          if (start) begin
            state_q        <= S_LOAD;
            byte_cnt_q     <= 2'd0;
            asm_q          <= '0;
            last_q         <= 1'b0;
            words_loaded_q <= '0;
            byte_ready_q   <= 1'b1;
            busy_q         <= 1'b1;
            done_q         <= 1'b0;
            overflow_q     <= 1'b0;
            cpu_hold_q     <= 1'b1;
          end
        end
        S_LOAD: begin
          if (last_q) begin
            // Final word was written in the previous cycle; release the CPU
            // only now so fetch never overlaps the last write.
            state_q    <= S_DONE;
            last_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b1;
            cpu_hold_q <= 1'b0;
          end else if (accept) begin
            if (words_loaded_q == MAX_CNT) begin
              // Bank already full: drop the byte, never wrap the address.
              state_q      <= S_ERROR;
              byte_cnt_q   <= 2'd0;
              asm_q        <= '0;
              byte_ready_q <= 1'b0;
              busy_q       <= 1'b0;
              overflow_q   <= 1'b1;
            end else begin
              if (byte_cnt_q == 2'd3 || byte_last) begin
                mem_we_q       <= 1'b1;
                mem_addr_q     <= words_loaded_q[ADDR_WIDTH-1:0];
                mem_wdata_q    <= word_d;
                words_loaded_q <= words_loaded_q + (ADDR_WIDTH+1)'(1);
                asm_q          <= '0;
                byte_cnt_q     <= 2'd0;
              end else begin
                asm_q      <= word_d;
                byte_cnt_q <= byte_cnt_q + 2'd1;
              end
              if (byte_last) begin
                last_q       <= 1'b1;
                byte_ready_q <= 1'b0;
              end
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign byte_ready   = byte_ready_q;
  assign mem_we       = mem_we_q;
  assign mem_addr     = mem_addr_q;
  assign mem_wdata    = mem_wdata_q;
  assign words_loaded = words_loaded_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign overflow_err = overflow_q;
  assign cpu_hold     = cpu_hold_q;

endmodule

// File: tb/tb_instr_mem_loader.sv
// tb/tb_instr_mem_loader.sv - directed table-driven bench for instr_mem_loader
module tb_instr_mem_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic       start_a, start_b, start_c;
  logic [7:0] byte_in;
  logic       byte_valid, byte_last;

  // a: defaults (big-endian, 16-bit address)
  logic        rdy_a, we_a, busy_a, done_a, ovf_a, hold_a;
  logic [15:0] addr_a;
  logic [31:0] wdata_a;
  logic [16:0] words_a;
  // b: little-endian
  logic        rdy_b, we_b, busy_b, done_b, ovf_b, hold_b;
  logic [15:0] addr_b;
  logic [31:0] wdata_b;
  logic [16:0] words_b;
  // c: 4-word bank
  logic        rdy_c, we_c, busy_c, done_c, ovf_c, hold_c;
  logic [1:0]  addr_c;
  logic [31:0] wdata_c;
  logic [2:0]  words_c;

  instr_mem_loader dut_a (
    .clk(clk), .reset(reset), .start(start_a), .byte_in(byte_in),
    .byte_valid(byte_valid), .byte_last(byte_last), .byte_ready(rdy_a),
    .mem_we(we_a), .mem_addr(addr_a), .mem_wdata(wdata_a),
    .words_loaded(words_a), .busy(busy_a), .done(done_a),
    .overflow_err(ovf_a), .cpu_hold(hold_a)
  );

  instr_mem_loader #(.BIG_ENDIAN(1'b0)) dut_b (
    .clk(clk), .reset(reset), .start(start_b), .byte_in(byte_in),
    .byte_valid(byte_valid), .byte_last(byte_last), .byte_ready(rdy_b),
    .mem_we(we_b), .mem_addr(addr_b), .mem_wdata(wdata_b),
    .words_loaded(words_b), .busy(busy_b), .done(done_b),
    .overflow_err(ovf_b), .cpu_hold(hold_b)
  );

  instr_mem_loader #(.ADDR_WIDTH(2)) dut_c (
    .clk(clk), .reset(reset), .start(start_c), .byte_in(byte_in),
    .byte_valid(byte_valid), .byte_last(byte_last), .byte_ready(rdy_c),
    .mem_we(we_c), .mem_addr(addr_c), .mem_wdata(wdata_c),
    .words_loaded(words_c), .busy(busy_c), .done(done_c),
    .overflow_err(ovf_c), .cpu_hold(hold_c)
  );

  typedef struct {
    logic        st;
    logic        v;
    logic        l;
    logic [7:0]  b;
    logic        we;
    logic [15:0] addr;
    logic [31:0] data;
    logic        rdy;
    logic        bsy;
    logic        dn;
    logic        hold;
    logic [16:0] words;
  } vec_t;

  vec_t vecs[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic vec_t mk(input int st, input int v, input int l, input int b,
                              input int we, input int addr, input int data,
                              input int rdy, input int bsy, input int dn,
                              input int hold, input int words);
    vec_t r;
    r.st = 1'(st);   r.v = 1'(v);   r.l = 1'(l);   r.b = 8'(b);
    r.we = 1'(we);   r.addr = 16'(addr);  r.data = 32'(data);
    r.rdy = 1'(rdy); r.bsy = 1'(bsy); r.dn = 1'(dn); r.hold = 1'(hold);
    r.words = 17'(words);
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Apply one cycle of inputs, then sample just after the rising edge.
  task automatic cyc(input int sa, input int sb, input int sc,
                     input int v, input int l, input int b);
    start_a    = 1'(sa);
    start_b    = 1'(sb);
    start_c    = 1'(sc);
    byte_valid = 1'(v);
    byte_last  = 1'(l);
    byte_in    = 8'(b);
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] acc;
    logic [7:0]  le_bytes [4];
    int          we_seen;

    reset = 1'b1;
    cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    reset = 1'b0;

    // reset state
    chk("rst a outs", 64'({we_a, addr_a, wdata_a, words_a}), 64'd0);
    chk("rst a flags", 64'({rdy_a, busy_a, done_a, ovf_a, hold_a}), 64'b00001);
    chk("rst b flags", 64'({rdy_b, busy_b, done_b, ovf_b, hold_b}), 64'b00001);
    chk("rst c flags", 64'({rdy_c, busy_c, done_c, ovf_c, hold_c, words_c}), 64'b00001_000);

    // st v l byte | we addr data | rdy bsy dn hold words
    // 8 bytes, big-endian
    vecs.push_back(mk(1,0,0,0,     0,0,0,           1,1,0,1,0));
    vecs.push_back(mk(0,1,0,'h01,  0,0,0,           1,1,0,1,0));
    vecs.push_back(mk(0,1,0,'h02,  0,0,0,           1,1,0,1,0));
    vecs.push_back(mk(0,1,0,'h03,  0,0,0,           1,1,0,1,0));
    vecs.push_back(mk(0,1,0,'h04,  1,0,'h01020304,  1,1,0,1,1));
    vecs.push_back(mk(0,1,0,'h05,  0,0,0,           1,1,0,1,1));
    vecs.push_back(mk(0,0,0,'h00,  0,0,0,           1,1,0,1,1));
    vecs.push_back(mk(0,1,0,'h06,  0,0,0,           1,1,0,1,1));
    vecs.push_back(mk(0,1,0,'h07,  0,0,0,           1,1,0,1,1));
    vecs.push_back(mk(0,1,1,'h08,  1,1,'h05060708,  0,1,0,1,2));
    vecs.push_back(mk(0,0,0,0,     0,0,0,           0,0,1,0,2));
    vecs.push_back(mk(0,1,0,'h99,  0,0,0,           0,0,1,0,2));
    // partial last word, start during a handshake is ignored
    vecs.push_back(mk(1,0,0,0,     0,0,0,           1,1,0,1,0));
    vecs.push_back(mk(0,1,0,'hAA,  0,0,0,           1,1,0,1,0));
    vecs.push_back(mk(0,1,0,'hBB,  0,0,0,           1,1,0,1,0));
    vecs.push_back(mk(0,1,0,'hCC,  0,0,0,           1,1,0,1,0));
    vecs.push_back(mk(0,1,0,'hDD,  1,0,'hAABBCCDD,  1,1,0,1,1));
    vecs.push_back(mk(1,1,0,'hEE,  0,0,0,           1,1,0,1,1));
    vecs.push_back(mk(0,1,1,'hFF,  1,1,'hEEFF0000,  0,1,0,1,2));
    vecs.push_back(mk(0,0,0,0,     0,0,0,           0,0,1,0,2));
    // reload from DONE
    vecs.push_back(mk(1,0,0,0,     0,0,0,           1,1,0,1,0));
    vecs.push_back(mk(0,1,0,'hDE,  0,0,0,           1,1,0,1,0));
    vecs.push_back(mk(0,1,0,'hAD,  0,0,0,           1,1,0,1,0));
    vecs.push_back(mk(0,1,0,'hBE,  0,0,0,           1,1,0,1,0));
    vecs.push_back(mk(0,1,1,'hEF,  1,0,'hDEADBEEF,  0,1,0,1,1));
    vecs.push_back(mk(0,0,0,0,     0,0,0,           0,0,1,0,1));

    for (int i = 0; i < vecs.size(); i++) begin
      cyc(vecs[i].st, 0, 0, vecs[i].v, vecs[i].l, vecs[i].b);
      chk($sformatf("v%0d we", i), 64'(we_a), 64'(vecs[i].we));
      if (vecs[i].we) begin
        chk($sformatf("v%0d addr", i), 64'(addr_a), 64'(vecs[i].addr));
        chk($sformatf("v%0d wdata", i), 64'(wdata_a), 64'(vecs[i].data));
      end
      chk($sformatf("v%0d flags", i), 64'({rdy_a, busy_a, done_a, hold_a}),
          64'({vecs[i].rdy, vecs[i].bsy, vecs[i].dn, vecs[i].hold}));
      chk($sformatf("v%0d words", i), 64'(words_a), 64'(vecs[i].words));
    end

    // overflow on a 4-word bank: 17 bytes
    cyc(0, 0, 1, 0, 0, 0);
    acc = 32'd0;
    we_seen = 0;
    for (int i = 1; i <= 17; i++) begin
      cyc(0, 0, 0, 1, 0, i);
      acc = {acc[23:0], 8'(i)};
      if (we_c) we_seen++;
      if (i % 4 == 0) begin
        chk($sformatf("ovf we b%0d", i), 64'(we_c), 64'd1);
        chk($sformatf("ovf addr b%0d", i), 64'(addr_c), 64'(i / 4 - 1));
        chk($sformatf("ovf wdata b%0d", i), 64'(wdata_c), 64'(acc));
      end else begin
        chk($sformatf("ovf nowe b%0d", i), 64'(we_c), 64'd0);
      end
    end
    chk("ovf flags", 64'({ovf_c, hold_c, rdy_c, done_c}), 64'b1100);
    chk("ovf words", 64'(words_c), 64'd4);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 0, 1, 0, 'h55);
      if (we_c) we_seen++;
    end
    chk("ovf write count", 64'(we_seen), 64'd4);
    chk("ovf sticky", 64'({ovf_c, hold_c, rdy_c}), 64'b110);
    cyc(0, 0, 1, 0, 0, 0);
    chk("ovf restart flags", 64'({ovf_c, hold_c, rdy_c, busy_c}), 64'b0111);
    chk("ovf restart words", 64'(words_c), 64'd0);
    cyc(0, 0, 0, 1, 0, 'h31);
    cyc(0, 0, 0, 1, 0, 'h32);
    cyc(0, 0, 0, 1, 0, 'h33);
    cyc(0, 0, 0, 1, 1, 'h34);
    chk("ovf reload we", 64'({we_c, addr_c}), 64'({1'b1, 2'd0}));
    chk("ovf reload wdata", 64'(wdata_c), 64'h31323334);
    cyc(0, 0, 0, 0, 0, 0);
    chk("ovf reload done", 64'({done_c, hold_c, words_c}), 64'({1'b1, 1'b0, 3'd1}));

    // little-endian, two idle cycles between bytes
    le_bytes = '{8'h11, 8'h22, 8'h33, 8'h44};
    cyc(0, 1, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      cyc(0, 0, 0, 1, 0, le_bytes[i]);
      chk($sformatf("le rdy b%0d", i), 64'(rdy_b), 64'd1);
      if (i == 3) begin
        chk("le we", 64'({we_b, addr_b}), 64'({1'b1, 16'd0}));
        chk("le wdata", 64'(wdata_b), 64'h44332211);
      end else begin
        chk($sformatf("le nowe b%0d", i), 64'(we_b), 64'd0);
      end
      for (int g = 0; g < 2; g++) begin
        cyc(0, 0, 0, 0, 0, 'hEE);
        chk($sformatf("le gap b%0d g%0d", i, g), 64'({we_b, rdy_b}), 64'b01);
      end
    end
    chk("le words", 64'(words_b), 64'd1);

    // reset after 6 of 8 bytes
    cyc(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 6; i++) begin
      cyc(0, 0, 0, 1, 0, 'h10 + i);
      if (i == 3) chk("rml first write", 64'({we_a, addr_a, wdata_a}), 64'({1'b1, 16'd0, 32'h10111213}));
    end
    reset = 1'b1;
    cyc(0, 0, 0, 1, 0, 'h16);
    reset = 1'b0;
    chk("rml outs", 64'({we_a, addr_a, wdata_a, words_a}), 64'd0);
    chk("rml flags", 64'({rdy_a, busy_a, done_a, ovf_a, hold_a}), 64'b00001);
    we_seen = 0;
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 0, 1, 0, 'h17);
      if (we_a) we_seen++;
    end
    chk("rml no write", 64'(we_seen), 64'd0);
    cyc(1, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 0, 'h21);
    cyc(0, 0, 0, 1, 0, 'h22);
    cyc(0, 0, 0, 1, 0, 'h23);
    cyc(0, 0, 0, 1, 0, 'h24);
    chk("rml reload we", 64'({we_a, addr_a, words_a}), 64'({1'b1, 16'd0, 17'd1}));
    chk("rml reload wdata", 64'(wdata_a), 64'h21222324);
    cyc(0, 0, 0, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/instr_mem_loader.md
Name: instr_mem_loader

Overview:
- Writer side of the CPU_NN instruction memory.
- Accepts the program image as a byte stream over a valid/ready handshake, packs bytes into 32-bit words and drives a synchronous write port into the instruction memory bank from address 0 upward.
- Holds the CPU (cpu_hold) until the whole image is written, so fetch never reads a partially loaded bank.

Parameters:
- ADDR_WIDTH, 16, word-address width of the instruction memory (bank depth 2**ADDR_WIDTH).
- DATA_WIDTH, 32, memory word width; fixed at 4 bytes.
- MAX_WORDS, 2**ADDR_WIDTH, capacity limit; a byte arriving after MAX_WORDS words have been written is an overflow.
- BIG_ENDIAN, 1, 1 = first byte of a word goes to [31:24] (hex-image order); 0 = first byte goes to [7:0].

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- reset  in  1  synchronous, active-high.
- start  in  1  one-cycle pulse; begins a load from address 0. Honoured in IDLE, DONE and ERROR; ignored in LOAD.
- byte_in  in  8  image byte.
- byte_valid  in  1  byte_in is valid.
- byte_last  in  1  marks the final image byte; qualified by byte_valid.
- byte_ready  out  1  loader accepts a byte this cycle; transfer occurs when byte_valid & byte_ready.
- mem_we  out  1  one-cycle write strobe to the instruction memory.
- mem_addr  out  ADDR_WIDTH  word address of the write.
- mem_wdata  out  DATA_WIDTH  assembled word.
- words_loaded  out  ADDR_WIDTH+1  count of words written in the current or last load.
- busy  out  1  high in LOAD.
- done  out  1  image fully written.
- overflow_err  out  1  image exceeded MAX_WORDS.
- cpu_hold  out  1  keeps the CPU in reset/stalled.

Behaviour:
- Reset values:
  - mem_we=0, mem_addr=0, mem_wdata=0, words_loaded=0, byte_ready=0.
  - busy=0, done=0, overflow_err=0, cpu_hold=1.
  - FSM=IDLE, byte counter=0, assembly register=0.
- FSM states are IDLE, LOAD and ERROR, plus DONE as the terminal state.
- IDLE:
  - byte_ready=0, cpu_hold=1.
  - On start: go to LOAD; clear write pointer, words_loaded and byte counter.
- LOAD, byte handling:
  - busy=1, byte_ready=1, cpu_hold=1.
  - Each accepted byte is placed into lane byte_cnt of the assembly register per BIG_ENDIAN; byte_cnt increments modulo 4.
- LOAD, word write:
  - When the 4th byte of a word is accepted, mem_we=1 on the next cycle, with mem_addr=write pointer and mem_wdata=completed word.
  - The write pointer and words_loaded increment in that same write cycle.
  - Write latency is exactly 1 cycle after the completing handshake.
  - Bytes continue to be accepted while the write is in progress; no stall.
- LOAD, byte_last:
  - If byte_last arrives with a byte that completes a word, that word is written normally, then the FSM goes to DONE.
  - If byte_last arrives mid-word (byte_cnt after the byte is 1..3), the unfilled lanes are zero-padded. The padded word is written 1 cycle later, then the FSM goes to DONE.
  - byte_ready=0 from the cycle after byte_last is accepted.
- Overflow:
  - A byte accepted while words_loaded == MAX_WORDS goes to ERROR; the byte is discarded and no write occurs.
  - A word completing at the last address is written normally; it is the subsequent byte that errors.
  - mem_addr never wraps.
- DONE:
  - done=1, cpu_hold=0, busy=0, byte_ready=0.
  - words_loaded holds the final count.
  - On start: clear done, assert cpu_hold and reload from address 0.
- ERROR:
  - overflow_err=1, cpu_hold=1, byte_ready=0.
  - Exits only on start (back to LOAD, overflow_err cleared) or on reset.
- Simultaneous events:
  - start in the same cycle as a byte handshake is ignored in LOAD.
  - A byte_valid without byte_ready is not consumed; the source must hold byte_in stable.
- Reset mid-load:
  - Returns to IDLE next edge and discards the partial word.
  - Memory words already written are left unchanged (the loader never clears memory).
  - cpu_hold returns to 1.
- mem_we is never high for more than one cycle per word and is never high outside LOAD or the final flush cycle.

Test Plan:
- 8 bytes, BIG_ENDIAN=1:
  - Stimulus: start, then 8 back-to-back bytes 01,02,..,08 with byte_last on 08.
  - Response: mem_we pulses with addr 0 data 0x01020304, then addr 1 data 0x05060708, each 1 cycle after its 4th byte.
  - Then done=1, cpu_hold=0, words_loaded=2.
- Partial last word:
  - Stimulus: 6 bytes AA,BB,CC,DD,EE,FF with byte_last on FF.
  - Response: writes 0xAABBCCDD @0 and 0xEEFF0000 @1; done=1, words_loaded=2.
- BIG_ENDIAN=0, gapped input:
  - Stimulus: bytes 11,22,33,44 with byte_valid gaps of 2 idle cycles between them.
  - Response: a single write 0x44332211 @0; no write during gaps; byte_ready stays 1 throughout.
- Overflow, ADDR_WIDTH=2 (MAX_WORDS=4):
  - Stimulus: 17 bytes.
  - Response: 4 writes at addr 0..3; the 17th byte sets overflow_err=1, cpu_hold stays 1, no 5th write.
  - A subsequent start clears the error and restarts at addr 0.
- Reset mid-load:
  - Stimulus: after 6 of 8 bytes, assert reset for one cycle.
  - Response: FSM in IDLE, all outputs at reset values, no write for bytes 5–6.
  - A subsequent start plus 4 bytes writes @0.
- Reload:
  - Stimulus: a start pulse in DONE, then 4 bytes with byte_last.
  - Response: done drops and cpu_hold rises on the edge after start; a new write @0; then done=1 with words_loaded=1.
